reset_sequencer: RTL and testbench

- Orders the release of several downstream reset domains after global reset or a soft-reset request.
- Holds every domain in reset, then releases each domain in index order, with a programmable gap between releases and a per-domain ready acknowledge.
- Sits between the power-on reset timer and the per-domain logic. Its `reset` input is normally driven by the timer's `reset_out`.
- Exposes sequencing status for debug LEDs and logic-analyser taps.

---
 rtl/reset_sequencer_if.sv | 23 ++
 rtl/reset_sequencer.sv | 55 +++++
 tb/tb_reset_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: soft-restart request, domain acks and sequencing status between the sequencer and its domains
interface reset_sequencer_if #(
  parameter int NUM_STAGES = 3,
  parameter int CNT_W = 4,
  parameter int IDX_W = 2
);
  logic soft_req;
  logic [NUM_STAGES-1:0] stage_ack;
  logic [NUM_STAGES-1:0] rst_out;
  logic busy;
  logic all_ready;
  logic fault;
  logic [IDX_W-1:0] stage_idx;
  logic [CNT_W-1:0] counter_out;
  modport master (
    input soft_req, stage_ack,
    output rst_out, busy, all_ready, fault, stage_idx, counter_out
  );
  modport slave (
    output soft_req, stage_ack,
    input rst_out, busy, all_ready, fault, stage_idx, counter_out
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: holds all domains in reset, then releases them in index order with a gap and an ack wait per domain
module reset_sequencer #(
  parameter int NUM_STAGES = 3,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES = 11,
  parameter int ACK_TIMEOUT = 15,
  parameter int CNT_W = 4,
  parameter int IDX_W = 2
) (
  input logic clk,
  input logic reset,
  reset_sequencer_if.master bus
);
  localparam logic [1:0] HOLD = 2'd0, GAP = 2'd1, WAIT_ACK = 2'd2, RUN = 2'd3;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_STAGES - 1);
  logic [1:0] state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [NUM_STAGES-1:0] rst_q;
  logic fault_q;
  logic ack;
  logic zero;
  logic timeout;
  assign ack = bus.stage_ack[idx];
  assign zero = cnt == '0;
  assign timeout = state == WAIT_ACK && !ack && zero;
  always_ff @(posedge clk) begin
    fault_q <= !reset && (fault_q || (!bus.soft_req && timeout));
    if (reset || bus.soft_req || timeout) begin
      state <= HOLD;
      cnt <= CNT_W'(HOLD_CYCLES);
      idx <= '0;
      rst_q <= '1;
    end else if (state == WAIT_ACK && ack) begin
      state <= idx == LAST ? RUN : GAP;
      cnt <= idx == LAST ? '0 : CNT_W'(GAP_CYCLES);
      idx <= idx == LAST ? idx : idx + 1'b1;
    end else if (!zero) begin
      cnt <= cnt - 1'b1;
    end else if (state == HOLD) begin
      state <= GAP;
      cnt <= CNT_W'(GAP_CYCLES);
    end else if (state == GAP) begin
      rst_q[idx] <= 1'b0;
      state <= WAIT_ACK;
      cnt <= CNT_W'(ACK_TIMEOUT);
    end
  end
  assign bus.rst_out = rst_q;
  assign bus.busy = state != RUN;
  assign bus.all_ready = state == RUN;
  assign bus.fault = fault_q;
  assign bus.stage_idx = idx;
  assign bus.counter_out = cnt;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: scoreboard bench, expected outputs queued per edge and compared as the edges arrive
module tb_reset_sequencer;
  localparam int NS = 3, HC = 4, GC = 11, AT = 15, CW = 4, IW = 2;
  localparam int RST = 0, BSY = 1, RDY = 2, FLT = 3, IDX = 4, CNT = 5;
  typedef struct {
    int cyc;
    int sel;
    int val;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int cyc = 0;
  int base = 0;
  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  string tags[6] = '{"rst_out", "busy", "all_ready", "fault", "stage_idx", "counter_out"};
  reset_sequencer_if #(.NUM_STAGES(NS), .CNT_W(CW), .IDX_W(IW)) bus ();
  reset_sequencer #(
    .NUM_STAGES(NS), .HOLD_CYCLES(HC), .GAP_CYCLES(GC),
    .ACK_TIMEOUT(AT), .CNT_W(CW), .IDX_W(IW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial assert ((2 ** CW) - 1 >= HC && (2 ** CW) - 1 >= GC && (2 ** CW) - 1 >= AT)
    else $fatal(1, "FAIL cnt_w too narrow for counter loads");
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic int obs(int sel);
    return sel == RST ? int'(bus.rst_out) : sel == BSY ? int'(bus.busy) :
           sel == RDY ? int'(bus.all_ready) : sel == FLT ? int'(bus.fault) :
           sel == IDX ? int'(bus.stage_idx) : int'(bus.counter_out);
  endfunction
  task automatic check(string t, int got, int want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d want %0d", t, cyc - base, got, want);
    end
  endtask
  task automatic exp_at(int k, int sel, int v);
    q.push_back('{base + k, sel, v});
  endtask
  always @(negedge clk) begin : monitor
    exp_t e;
    while (q.size() != 0 && q[0].cyc <= cyc) begin
      e = q.pop_front();
      check(tags[e.sel], obs(e.sel), e.val);
    end
  end
  task automatic start(logic [NS-1:0] ack);
    reset = 1'b1;
    bus.soft_req = 1'b0;
    bus.stage_ack = ack;
    @(posedge clk);
    #2;
    reset = 1'b0;
    base = cyc;
  endtask
  task automatic at(int k);
    while (cyc < base + k) begin
      @(posedge clk);
      #2;
    end
  endtask
  task automatic drain();
    int lim = cyc + 100;
    while (q.size() != 0 && cyc < lim) @(negedge clk);
    #1;
    check("drain", q.size(), 0);
    q.delete();
  endtask
  initial begin
    bus.soft_req = 1'b0;
    bus.stage_ack = '0;
    // full sequence with acks tied high, then a soft_req pulse in RUN
    start(3'b111);
    exp_at(0, RST, 7); exp_at(0, BSY, 1); exp_at(0, RDY, 0);
    exp_at(0, FLT, 0); exp_at(0, IDX, 0); exp_at(0, CNT, 4);
    exp_at(16, RST, 7); exp_at(16, CNT, 0);
    exp_at(17, RST, 6); exp_at(17, IDX, 0); exp_at(17, CNT, 15);
    exp_at(18, IDX, 1); exp_at(18, CNT, 11);
    exp_at(29, RST, 6); exp_at(30, RST, 4);
    exp_at(42, RST, 4); exp_at(43, RST, 0); exp_at(43, RDY, 0); exp_at(43, BSY, 1);
    exp_at(44, RDY, 1); exp_at(44, BSY, 0); exp_at(44, FLT, 0);
    exp_at(44, IDX, 2); exp_at(44, CNT, 0); exp_at(44, RST, 0);
    exp_at(49, RDY, 1);
    exp_at(50, RST, 7); exp_at(50, BSY, 1); exp_at(50, RDY, 0);
    exp_at(50, IDX, 0); exp_at(50, CNT, 4);
    exp_at(66, RST, 7); exp_at(67, RST, 6);
    at(49); bus.soft_req = 1'b1;
    at(50); bus.soft_req = 1'b0;
    drain();
    // late ack on domain 1: counter runs 15..10 before the ack lands
    start(3'b101);
    exp_at(17, RST, 6); exp_at(29, RST, 6);
    exp_at(30, RST, 4); exp_at(30, IDX, 1); exp_at(30, CNT, 15); exp_at(30, BSY, 1);
    for (int k = 31; k <= 35; k++) exp_at(k, CNT, 45 - k);
    exp_at(35, IDX, 1); exp_at(35, RDY, 0);
    exp_at(36, IDX, 2); exp_at(36, CNT, 11); exp_at(36, RST, 4);
    exp_at(47, RST, 4); exp_at(47, CNT, 0);
    exp_at(48, RST, 0); exp_at(48, CNT, 15); exp_at(48, RDY, 0);
    exp_at(49, RDY, 1); exp_at(49, FLT, 0);
    at(35); bus.stage_ack = 3'b111;
    drain();
    // domain 0 never acks (other acks ignored), timeout restart, then reset with fault set
    start(3'b110);
    exp_at(17, RST, 6); exp_at(17, CNT, 15);
    exp_at(32, RST, 6); exp_at(32, CNT, 0); exp_at(32, FLT, 0); exp_at(32, IDX, 0);
    exp_at(33, RST, 7); exp_at(33, FLT, 1); exp_at(33, IDX, 0); exp_at(33, CNT, 4); exp_at(33, BSY, 1);
    exp_at(49, RST, 7); exp_at(50, RST, 6); exp_at(50, FLT, 1);
    exp_at(54, FLT, 1); exp_at(54, CNT, 11);
    exp_at(55, RST, 7); exp_at(55, FLT, 0); exp_at(55, BSY, 1);
    exp_at(55, RDY, 0); exp_at(55, IDX, 0); exp_at(55, CNT, 4);
    at(54); reset = 1'b1;
    at(55); reset = 1'b0;
    drain();
    // soft_req held over three edges during the gap of stage 2
    start(3'b111);
    exp_at(34, IDX, 2); exp_at(34, CNT, 8); exp_at(34, RST, 4);
    exp_at(35, RST, 7); exp_at(35, IDX, 0); exp_at(35, CNT, 4); exp_at(35, BSY, 1);
    exp_at(37, CNT, 4); exp_at(37, RST, 7);
    exp_at(38, CNT, 3);
    exp_at(53, RST, 7); exp_at(54, RST, 6);
    at(34); bus.soft_req = 1'b1;
    at(37); bus.soft_req = 1'b0;
    drain();
    // ack arriving on the same edge the ack counter is zero beats the timeout
    start(3'b000);
    exp_at(32, CNT, 0); exp_at(32, RST, 6);
    exp_at(33, FLT, 0); exp_at(33, RST, 6); exp_at(33, IDX, 1);
    exp_at(33, CNT, 11); exp_at(33, BSY, 1);
    at(32); bus.stage_ack = 3'b001;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
